// File: rtl/nexys_starship_gcd_param.sv
// Parametrised binary (Stein) GCD engine with Start/Ack handshake and CEN single-stepping.
// Optional step counter output Steps is enabled by defining GCD_STEP_COUNT_EN.
module nexys_starship_gcd_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             Start,
    input  logic             Ack,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AB_GCD,
    output logic [CNT_W-1:0] i_count,
    output logic             Zero_Err,
    output logic             q_I,
    output logic             q_Sub,
    output logic             q_Mult,
    output logic             q_Done
`ifdef GCD_STEP_COUNT_EN
    ,
    output logic [15:0]      Steps
`endif
);

    typedef enum logic [3:0] {
        StI    = 4'b0001,
        StSub  = 4'b0010,
        StMult = 4'b0100,
        StDone = 4'b1000
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StI: begin
                a_d   = Ain;
                b_d   = Bin;
                cnt_d = '0;
                gcd_d = '0;
                err_d = 1'b0;
                if (Start) begin
                    if (Ain != '0 && Bin != '0) begin
                        state_d = StSub;
                    end else begin
                        // Zero operand: gcd(x,0)=x, no iteration needed
                        state_d = StDone;
                        gcd_d   = Ain | Bin;
                        err_d   = (Ain == '0) && (Bin == '0);
                    end
                end
            end
            StSub: begin
                if (CEN) begin
                    if (a_q == b_q) begin
                        gcd_d   = a_q;
                        state_d = (cnt_q != '0) ? StMult : StDone;
                    end else if (a_q < b_q) begin
                        a_d = b_q;
                        b_d = a_q;
                    end else if (a_q[0] && b_q[0]) begin
                        a_d = a_q - b_q;
                    end else if (!a_q[0] && !b_q[0]) begin
                        a_d   = a_q >> 1;
                        b_d   = b_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else begin
                        b_d = b_q >> 1;
                    end
                end
            end
            StMult: begin
                if (CEN) begin
                    gcd_d = gcd_q << 1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (Ack) begin
                    state_d = StI;
                end
            end
            default: begin
                // Non-one-hot state: recover to I with everything cleared
                state_d = StI;
                a_d     = '0;
                b_d     = '0;
                gcd_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StI;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef GCD_STEP_COUNT_EN
    logic [15:0] steps_q, steps_d;

    always_comb begin
        steps_d = steps_q;
        if (state_q == StSub || state_q == StMult) begin
            if (CEN && steps_q != 16'hFFFF) begin
                steps_d = steps_q + 16'd1;
            end
        end else if (state_q != StDone) begin
            steps_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign Steps = steps_q;
`endif

    assign A        = a_q;
    assign B        = b_q;
    assign AB_GCD   = gcd_q;
    assign i_count  = cnt_q;
    assign Zero_Err = err_q;
    assign {q_Done, q_Mult, q_Sub, q_I} = state_q;

endmodule

// File: tb/tb_nexys_starship_gcd_param.sv
// Scoreboard bench for nexys_starship_gcd_param: 8-bit and 16-bit instances sharing clock/reset.
module tb_nexys_starship_gcd_param;

    logic Clk, Reset, CEN;

    logic        start8, ack8;
    logic [7:0]  ain8, bin8, a8, b8, gcd8;
    logic [3:0]  cnt8;
    logic        err8, qi8, qs8, qm8, qd8;

    logic        start16, ack16;
    logic [15:0] ain16, bin16, a16, b16, gcd16;
    logic [4:0]  cnt16;
    logic        err16, qi16, qs16, qm16, qd16;

`ifdef GCD_STEP_COUNT_EN
    logic [15:0] steps8, steps16;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] gcd;
        logic        err;
        logic [15:0] steps;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    logic prev8 = 1'b0;
    logic prev16 = 1'b0;
    logic mult16_seen = 1'b0;

    nexys_starship_gcd_param #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(start8), .Ack(ack8),
        .Ain(ain8), .Bin(bin8), .A(a8), .B(b8), .AB_GCD(gcd8), .i_count(cnt8),
        .Zero_Err(err8), .q_I(qi8), .q_Sub(qs8), .q_Mult(qm8), .q_Done(qd8)
`ifdef GCD_STEP_COUNT_EN
        , .Steps(steps8)
`endif
    );

    nexys_starship_gcd_param #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(start16), .Ack(ack16),
        .Ain(ain16), .Bin(bin16), .A(a16), .B(b16), .AB_GCD(gcd16), .i_count(cnt16),
        .Zero_Err(err16), .q_I(qi16), .q_Sub(qs16), .q_Mult(qm16), .q_Done(qd16)
`ifdef GCD_STEP_COUNT_EN
        , .Steps(steps16)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result monitors: compare on entry to DONE against the oldest expectation
    always @(negedge Clk) begin
        if (qd8 && !prev8) begin
            if (q8.size() == 0) begin
                chk("sb8_unexpected_done", 32'(qd8), 0);
            end else begin
                e8 = q8.pop_front();
                chk("sb8_gcd", 32'(gcd8), 32'(e8.gcd));
                chk("sb8_icount", 32'(cnt8), 0);
                chk("sb8_zero_err", 32'(err8), 32'(e8.err));
`ifdef GCD_STEP_COUNT_EN
                chk("sb8_steps", 32'(steps8), 32'(e8.steps));
`endif
            end
        end
        prev8 = qd8;
    end

    always @(negedge Clk) begin
        if (qm16) mult16_seen = 1'b1;
        if (qd16 && !prev16) begin
            if (q16.size() == 0) begin
                chk("sb16_unexpected_done", 32'(qd16), 0);
            end else begin
                e16 = q16.pop_front();
                chk("sb16_gcd", 32'(gcd16), 32'(e16.gcd));
                chk("sb16_icount", 32'(cnt16), 0);
                chk("sb16_zero_err", 32'(err16), 32'(e16.err));
`ifdef GCD_STEP_COUNT_EN
                chk("sb16_steps", 32'(steps16), 32'(e16.steps));
`endif
            end
        end
        prev16 = qd16;
    end

    // Called at a negedge; returns at the negedge after Start was taken
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit push,
                          input logic [15:0] g, input logic err, input logic [15:0] st);
        if (push) q8.push_back('{gcd: g, err: err, steps: st});
        ain8 = a;
        bin8 = b;
        start8 = 1'b1;
        @(negedge Clk);
        start8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] g, input logic [15:0] st);
        q16.push_back('{gcd: g, err: 1'b0, steps: st});
        ain16 = a;
        bin16 = b;
        start16 = 1'b1;
        @(negedge Clk);
        start16 = 1'b0;
    endtask

    task automatic wait_done8(input string name);
        int n = 0;
        while (!qd8 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk(name, 32'(qd8), 1);
    endtask

    task automatic wait_done16(input string name);
        int n = 0;
        while (!qd16 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk(name, 32'(qd16), 1);
    endtask

    task automatic ack8_pulse(input string name);
        ack8 = 1'b1;
        @(negedge Clk);
        ack8 = 1'b0;
        chk(name, 32'(qi8), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    logic [7:0] seq_a [6] = '{8'd36, 8'd18, 8'd9, 8'd9, 8'd6, 8'd3};
    logic [7:0] seq_b [6] = '{8'd24, 8'd12, 8'd6, 8'd3, 8'd3, 8'd3};

    initial begin
        Reset = 1'b0; CEN = 1'b1;
        start8 = 1'b0; ack8 = 1'b0; ain8 = '0; bin8 = '0;
        start16 = 1'b0; ack16 = 1'b0; ain16 = '0; bin16 = '0;
        #12;
        chk("rst_q_I", 32'(qi8), 1);
        chk("rst_onehot", 32'({qd8, qm8, qs8, qi8}), 1);
        chk("rst_A", 32'(a8), 0);
        chk("rst_B", 32'(b8), 0);
        chk("rst_gcd", 32'(gcd8), 0);
        chk("rst_icount", 32'(cnt8), 0);
        chk("rst_zero_err", 32'(err8), 0);
        #1 Reset = 1'b1;
        @(negedge Clk);

        // 36/24 with full trace of SUB and MULT cycles
        issue8(8'd36, 8'd24, 1'b1, 16'd12, 1'b0, 16'd8);
        for (int i = 0; i < 6; i++) begin
            chk("trace_q_Sub", 32'(qs8), 1);
            chk("trace_A", 32'(a8), 32'(seq_a[i]));
            chk("trace_B", 32'(b8), 32'(seq_b[i]));
            @(negedge Clk);
        end
        for (int i = 0; i < 2; i++) begin
            chk("trace_q_Mult", 32'(qm8), 1);
            @(negedge Clk);
        end
        wait_done8("done_36_24");
        ack8_pulse("ack_36_24");

        // Zero-operand short-circuit
        issue8(8'd0, 8'd45, 1'b1, 16'd45, 1'b0, 16'd0);
        chk("zero_done_next_cycle", 32'(qd8), 1);
        ack8_pulse("ack_0_45");
        issue8(8'd0, 8'd0, 1'b1, 16'd0, 1'b1, 16'd0);
        chk("zerozero_done_next_cycle", 32'(qd8), 1);
        ack8_pulse("ack_0_0");

        // CEN pattern 1,0,0,1 during SUB
        issue8(8'd36, 8'd24, 1'b1, 16'd12, 1'b0, 16'd8);
        @(negedge Clk);
        chk("cen_step_A", 32'(a8), 18);
        CEN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("cen_hold_A", 32'(a8), 18);
            chk("cen_hold_B", 32'(b8), 12);
            chk("cen_hold_icount", 32'(cnt8), 1);
            chk("cen_hold_q_Sub", 32'(qs8), 1);
        end
        CEN = 1'b1;
        wait_done8("done_cen");
        ack8_pulse("ack_cen");

        // Asynchronous reset mid-SUB, between clock edges
        issue8(8'd36, 8'd24, 1'b0, 16'd0, 1'b0, 16'd0);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("arst_q_I", 32'(qi8), 1);
        chk("arst_q_Sub", 32'(qs8), 0);
        chk("arst_A", 32'(a8), 0);
        chk("arst_B", 32'(b8), 0);
        chk("arst_gcd", 32'(gcd8), 0);
        chk("arst_icount", 32'(cnt8), 0);
`ifdef GCD_STEP_COUNT_EN
        chk("arst_steps", 32'(steps8), 0);
`endif
        #1 Reset = 1'b1;
        @(negedge Clk);

        // Handshake: Ack ignored in I and SUB, Start ignored in SUB and DONE
        ack8 = 1'b1;
        @(negedge Clk);
        ack8 = 1'b0;
        chk("ack_in_I_ignored", 32'(qi8), 1);
        issue8(8'd36, 8'd24, 1'b1, 16'd12, 1'b0, 16'd8);
        ack8 = 1'b1;
        start8 = 1'b1;
        @(negedge Clk);
        ack8 = 1'b0;
        start8 = 1'b0;
        chk("ack_start_in_Sub_ignored", 32'(qs8), 1);
        chk("sub_progress_A", 32'(a8), 18);
        wait_done8("done_hs");
        start8 = 1'b1;
        @(negedge Clk);
        chk("start_in_Done_ignored", 32'(qd8), 1);
        ack8 = 1'b1;
        @(negedge Clk);
        chk("start_ack_goes_I", 32'(qi8), 1);
        chk("start_ack_not_Sub", 32'(qs8), 0);
        ack8 = 1'b0;
        start8 = 1'b0;
        @(negedge Clk);
        chk("stays_in_I", 32'(qi8), 1);

        // 16-bit instance
        issue16(16'd65535, 16'd255, 16'd255, 16'd10);
        wait_done16("done16_65535_255");
        ack16 = 1'b1;
        @(negedge Clk);
        ack16 = 1'b0;
        chk("ack16_a", 32'(qi16), 1);
        mult16_seen = 1'b0;
        issue16(16'd32768, 16'd49152, 16'd16384, 16'd33);
        wait_done16("done16_32768_49152");
        chk("mult16_visited", 32'(mult16_seen), 1);
        ack16 = 1'b1;
        @(negedge Clk);
        ack16 = 1'b0;
        chk("ack16_b", 32'(qi16), 1);

        @(negedge Clk);
        chk("sb8_drained", q8.size(), 0);
        chk("sb16_drained", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
